// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/debug arbiter for the single-port data memory
// Optional bus lock for the debug port is enabled with `define DMEM_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_core_q, rd_core_d;
    logic             rd_dbg_q, rd_dbg_d;
    logic             in_lock;
    logic             wait_full;

`ifdef DMEM_LOCK_EN
    typedef enum logic {ARB, LOCK} state_t;
    state_t state_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ARB;
        end else begin
            case (state_q)
                ARB:     if (dbg_gnt && dbg_lock) state_q <= LOCK;
                LOCK:    if (!dbg_lock) state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end

    assign in_lock = (state_q == LOCK);
`else
    logic dbg_lock_unused;
    assign dbg_lock_unused = dbg_lock;
    assign in_lock         = 1'b0;
`endif

    // MAX_WAIT=0 means the debug port always wins a contested cycle.
    assign wait_full = (MAX_WAIT == 0) ? 1'b1 : (wait_cnt_q == MAX_CNT);

    // Grants are gated by n_rst so nothing reaches memory while in reset.
    always_comb begin
        dbg_gnt  = n_rst & dbg_req & (in_lock | ~core_req | wait_full);
        core_gnt = n_rst & core_req & ~in_lock & ~dbg_gnt;
        mem_en   = core_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end else if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt || in_lock) begin
            wait_cnt_d = '0;
        end else if (!wait_full) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        rd_core_d = core_gnt & ~core_we;
        rd_dbg_d  = dbg_gnt & ~dbg_we;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt_q <= '0;
            rd_core_q  <= 1'b0;
            rd_dbg_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_core_q  <= rd_core_d;
            rd_dbg_q   <= rd_dbg_d;
        end
    end

    // Each return routes by the flag of the read that produced it.
    assign core_rvalid = rd_core_q;
    assign dbg_rvalid  = rd_dbg_q;
    assign core_rdata  = rd_core_q ? mem_rdata : '0;
    assign dbg_rdata   = rd_dbg_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk;
    logic        n_rst;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [9:0]  core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem_model [0:1023];

    int checks;
    int failures;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .n_rst(n_rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [9:0]  caddr;
        logic [31:0] cwd;
        logic        dreq;
        logic        dwe;
        logic [9:0]  daddr;
        logic [31:0] dwd;
        logic        e_cgnt;
        logic        e_dgnt;
        logic        e_crv;
        logic [31:0] e_crd;
        logic        e_drv;
        logic [31:0] e_drd;
        logic [9:0]  e_maddr;
        logic [31:0] e_mwd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic creq, input logic cwe, input logic [9:0] caddr,
                          input logic [31:0] cwd, input logic dreq, input logic dwe,
                          input logic [9:0] daddr, input logic [31:0] dwd);
        core_req   = creq;
        core_we    = cwe;
        core_addr  = caddr;
        core_wdata = cwd;
        dbg_req    = dreq;
        dbg_we     = dwe;
        dbg_addr   = daddr;
        dbg_wdata  = dwd;
    endtask

    task automatic step(input logic creq, input logic cwe, input logic [9:0] caddr,
                        input logic [31:0] cwd, input logic dreq, input logic dwe,
                        input logic [9:0] daddr, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        set_in(creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, ".core_gnt"}, {31'd0, core_gnt}, 32'd0);
        chk({name, ".dbg_gnt"}, {31'd0, dbg_gnt}, 32'd0);
        chk({name, ".core_rvalid"}, {31'd0, core_rvalid}, 32'd0);
        chk({name, ".dbg_rvalid"}, {31'd0, dbg_rvalid}, 32'd0);
        chk({name, ".core_rdata"}, core_rdata, 32'd0);
        chk({name, ".dbg_rdata"}, dbg_rdata, 32'd0);
        chk({name, ".mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({name, ".mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({name, ".mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({name, ".mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mem_rdata = 32'd0;
        for (int i = 0; i < 1024; i++) mem_model[i] = 32'd0;

        //          creq cwe caddr cwd           dreq dwe daddr dwd     cg dg crv crd           drv drd     maddr mwd
        vecs[0]  = '{0, 0, 10'd0, 32'd0,        0, 0, 10'd0, 32'd0,   0, 0, 0, 32'd0,        0, 32'd0,   10'd0, 32'd0};
        vecs[1]  = '{1, 1, 10'd5, 32'hDEADBEEF, 0, 0, 10'd0, 32'd0,   1, 0, 0, 32'd0,        0, 32'd0,   10'd5, 32'hDEADBEEF};
        vecs[2]  = '{1, 0, 10'd5, 32'd0,        0, 0, 10'd0, 32'd0,   1, 0, 0, 32'd0,        0, 32'd0,   10'd5, 32'd0};
        vecs[3]  = '{0, 0, 10'd0, 32'd0,        0, 0, 10'd0, 32'd0,   0, 0, 1, 32'hDEADBEEF, 0, 32'd0,   10'd0, 32'd0};
        vecs[4]  = '{0, 0, 10'd0, 32'd0,        1, 1, 10'd0, 32'd100, 0, 1, 0, 32'd0,        0, 32'd0,   10'd0, 32'd100};
        vecs[5]  = '{1, 0, 10'd0, 32'd0,        0, 0, 10'd0, 32'd0,   1, 0, 0, 32'd0,        0, 32'd0,   10'd0, 32'd0};
        vecs[6]  = '{0, 0, 10'd0, 32'd0,        1, 0, 10'd0, 32'd0,   0, 1, 1, 32'd100,      0, 32'd0,   10'd0, 32'd0};
        vecs[7]  = '{1, 0, 10'd5, 32'd0,        0, 0, 10'd0, 32'd0,   1, 0, 0, 32'd0,        1, 32'd100, 10'd5, 32'd0};
        vecs[8]  = '{0, 0, 10'd0, 32'd0,        1, 0, 10'd0, 32'd0,   0, 1, 1, 32'hDEADBEEF, 0, 32'd0,   10'd0, 32'd0};
        vecs[9]  = '{0, 0, 10'd0, 32'd0,        0, 0, 10'd0, 32'd0,   0, 0, 0, 32'd0,        1, 32'd100, 10'd0, 32'd0};
        vecs[10] = '{1, 0, 10'd5, 32'd0,        1, 0, 10'd0, 32'd0,   1, 0, 0, 32'd0,        0, 32'd0,   10'd5, 32'd0};
        vecs[11] = '{0, 0, 10'd0, 32'd0,        0, 0, 10'd0, 32'd0,   0, 0, 1, 32'hDEADBEEF, 0, 32'd0,   10'd0, 32'd0};

        // Reset with both requesters active: nothing may leak out.
        n_rst    = 1'b0;
        dbg_lock = 1'b0;
        set_in(1, 1, 10'd7, 32'h55, 1, 1, 10'd8, 32'h66);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk);
        #1;
        set_in(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
        @(negedge clk);
        chk("reset_no_write", mem_model[7], 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                 vecs[i].dreq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwd);
            chk($sformatf("v%0d.core_gnt", i), {31'd0, core_gnt}, {31'd0, vecs[i].e_cgnt});
            chk($sformatf("v%0d.dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, vecs[i].e_dgnt});
            chk($sformatf("v%0d.mem_en", i), {31'd0, mem_en}, {31'd0, vecs[i].e_cgnt | vecs[i].e_dgnt});
            chk($sformatf("v%0d.mem_addr", i), {22'd0, mem_addr}, {22'd0, vecs[i].e_maddr});
            chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_mwd);
            chk($sformatf("v%0d.core_rvalid", i), {31'd0, core_rvalid}, {31'd0, vecs[i].e_crv});
            chk($sformatf("v%0d.core_rdata", i), core_rdata, vecs[i].e_crd);
            chk($sformatf("v%0d.dbg_rvalid", i), {31'd0, dbg_rvalid}, {31'd0, vecs[i].e_drv});
            chk($sformatf("v%0d.dbg_rdata", i), dbg_rdata, vecs[i].e_drd);
        end

        // Both held: core wins MW cycles, then debug gets one slot.
        for (int i = 0; i < 2 * (MW + 1); i++) begin
            step(1, 1, 10'd20, 32'd1, 1, 1, 10'd21, 32'd2);
            chk($sformatf("starve%0d.core_gnt", i), {31'd0, core_gnt},
                {31'd0, (i % (MW + 1)) != MW});
            chk($sformatf("starve%0d.dbg_gnt", i), {31'd0, dbg_gnt},
                {31'd0, (i % (MW + 1)) == MW});
        end

        // Dropping dbg_req clears the wait count.
        for (int i = 0; i < 3; i++) step(1, 1, 10'd20, 32'd1, 1, 1, 10'd21, 32'd2);
        step(1, 1, 10'd20, 32'd1, 0, 0, 10'd0, 32'd0);
        for (int i = 0; i <= MW; i++) begin
            step(1, 1, 10'd20, 32'd1, 1, 1, 10'd21, 32'd2);
            chk($sformatf("clr%0d.dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, i == MW});
        end

        // Reset mid-operation: pending read dropped, wait count cleared, reset-cycle write lost.
        for (int i = 0; i < 3; i++) step(1, 1, 10'd20, 32'd1, 1, 1, 10'd21, 32'd2);
        step(1, 0, 10'd5, 32'd0, 1, 1, 10'd21, 32'd2);
        chk("rst_mid.core_gnt", {31'd0, core_gnt}, 32'd1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        set_in(1, 1, 10'd5, 32'h12345678, 1, 1, 10'd21, 32'd3);
        @(negedge clk);
        chk_quiet("rst_mid");
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        set_in(1, 1, 10'd22, 32'd4, 1, 1, 10'd21, 32'd5);
        @(negedge clk);
        chk("post_rst0.core_gnt", {31'd0, core_gnt}, 32'd1);
        chk("post_rst0.core_rvalid", {31'd0, core_rvalid}, 32'd0);
        for (int i = 1; i <= MW; i++) begin
            step(1, 1, 10'd22, 32'd4, 1, 1, 10'd21, 32'd5);
            chk($sformatf("post_rst%0d.dbg_gnt", i), {31'd0, dbg_gnt}, {31'd0, i == MW});
        end
        step(1, 0, 10'd5, 32'd0, 0, 0, 10'd0, 32'd0);
        step(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
        chk("post_rst.rd5", core_rdata, 32'hDEADBEEF);

`ifdef DMEM_LOCK_EN
        // Locked debug burst holds off the core until the edge after dbg_lock drops.
        dbg_lock = 1'b1;
        step(0, 0, 10'd0, 32'd0, 1, 1, 10'd30, 32'd7);
        chk("lock0.dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step(1, 1, 10'd31, 32'd8, 1, 1, 10'd30, 32'd7);
            chk($sformatf("lock%0d.core_gnt", i), {31'd0, core_gnt}, 32'd0);
            chk($sformatf("lock%0d.dbg_gnt", i), {31'd0, dbg_gnt}, 32'd1);
        end
        @(posedge clk);
        #1;
        dbg_lock = 1'b0;
        set_in(1, 1, 10'd31, 32'd8, 0, 0, 10'd0, 32'd0);
        @(negedge clk);
        chk("unlock0.core_gnt", {31'd0, core_gnt}, 32'd0);
        step(1, 1, 10'd31, 32'd8, 0, 0, 10'd0, 32'd0);
        chk("unlock1.core_gnt", {31'd0, core_gnt}, 32'd1);
`else
        // Without the lock feature dbg_lock has no effect on arbitration.
        dbg_lock = 1'b1;
        step(0, 0, 10'd0, 32'd0, 1, 1, 10'd30, 32'd7);
        step(1, 1, 10'd31, 32'd8, 1, 1, 10'd30, 32'd7);
        chk("nolock.core_gnt", {31'd0, core_gnt}, 32'd1);
        chk("nolock.dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
        dbg_lock = 1'b0;
`endif

        step(0, 0, 10'd0, 32'd0, 0, 0, 10'd0, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
